// File: rtl/hp_pkg.sv
// Shared types and defaults for the player hit-point controller.
package hp_pkg;

    typedef enum logic [1:0] {
        ALIVE  = 2'b00,
        IFRAME = 2'b01,
        DEAD   = 2'b10
    } hp_state_t;

    localparam int HPW_DEF          = 3;
    localparam int MAX_HP_DEF       = 7;
    localparam int INIT_HP_DEF      = 7;
    localparam int IFRAMES_DEF      = 60;
`ifdef HP_REGEN_EN
    localparam int REGEN_PERIOD_DEF = 120;
`endif

    // Counter width for values 0..n; never below 3 so bit 2 exists for the blink strobe.
    function automatic int cnt_width(input int n);
        return ($clog2(n + 1) < 3) ? 3 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Loadable down-counter advanced by frame ticks, with a zero flag.
module frame_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         zero
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hp_controller.sv
// Player hit-point controller: damage/heal/revive, invincibility frames, dead flag, blink strobe.
// Optional build macro HP_REGEN_EN adds periodic +1 hp regeneration while ALIVE.
module hp_controller
    import hp_pkg::*;
#(
    parameter int HPW          = HPW_DEF,
    parameter int MAX_HP       = MAX_HP_DEF,
    parameter int INIT_HP      = INIT_HP_DEF,
`ifdef HP_REGEN_EN
    parameter int REGEN_PERIOD = REGEN_PERIOD_DEF,
`endif
    parameter int IFRAMES      = IFRAMES_DEF
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           frame_tick,
    input  logic           damage,
    input  logic [HPW-1:0] damage_amt,
    input  logic           heal,
    input  logic [HPW-1:0] heal_amt,
    input  logic           revive,
    output logic [HPW-1:0] hp,
    output logic           invincible,
    output logic           dead,
    output logic           hit_flash
);

    localparam int             SW     = HPW + 2;
    localparam int             IW     = cnt_width(IFRAMES);
    localparam logic [HPW-1:0] MAX_V  = HPW'(MAX_HP);
    localparam logic [HPW-1:0] INIT_V = HPW'(INIT_HP);

    hp_state_t             state, state_d;
    logic [HPW-1:0]        hp_d;
    logic                  dmg_acc, heal_en, evt;
    logic signed [SW-1:0]  sum;
    logic [HPW-1:0]        clamped;

    logic                  iframe_clr, iframe_load, iframe_tick, iframe_zero;
    logic [IW-1:0]         iframe_cnt;
    logic                  regen_fire;

    frame_counter #(.W(IW)) u_iframe (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .clr      (iframe_clr),
        .load     (iframe_load),
        .load_val (IW'(IFRAMES)),
        .tick     (iframe_tick),
        .count    (iframe_cnt),
        .zero     (iframe_zero)
    );

    // Signed headroom keeps over/underflow visible so the clamp never sees a wrapped value.
    always_comb begin
        dmg_acc = damage && (damage_amt != '0) && (state == ALIVE) && !revive;
        heal_en = heal && (state != DEAD) && !revive;
        evt     = dmg_acc || heal_en;

        sum = $signed({2'b00, hp});
        if (heal_en) sum = sum + $signed({2'b00, heal_amt});
        if (dmg_acc) sum = sum - $signed({2'b00, damage_amt});

        if (sum[SW-1])                        clamped = '0;
        else if (sum > $signed(SW'(MAX_HP)))  clamped = MAX_V;
        else                                  clamped = sum[HPW-1:0];
    end

`ifdef HP_REGEN_EN
    localparam int RW = cnt_width(REGEN_PERIOD);

    logic          regen_clr, regen_load, regen_tick, regen_zero;
    logic [RW-1:0] regen_cnt;

    // Counter rests at zero; the first tick arms it with PERIOD-1, so the PERIOD-th tick fires.
    always_comb begin
        regen_tick = (state == ALIVE) && frame_tick && !revive && !evt && (hp < MAX_V);
        regen_fire = regen_tick && ((REGEN_PERIOD == 1) || (regen_cnt == RW'(1)));
        regen_load = regen_tick && regen_zero;
        regen_clr  = revive || (state != ALIVE) || dmg_acc || (hp == MAX_V) || regen_fire;
    end

    frame_counter #(.W(RW)) u_regen (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .clr      (regen_clr),
        .load     (regen_load),
        .load_val (RW'(REGEN_PERIOD - 1)),
        .tick     (regen_tick),
        .count    (regen_cnt),
        .zero     (regen_zero)
    );
`else
    assign regen_fire = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state;
        hp_d        = hp;
        iframe_clr  = 1'b0;
        iframe_load = 1'b0;
        iframe_tick = 1'b0;

        if (revive) begin
            state_d    = ALIVE;
            hp_d       = INIT_V;
            iframe_clr = 1'b1;
        end else begin
            unique case (state)
                ALIVE: begin
                    if (dmg_acc) begin
                        hp_d = clamped;
                        if (clamped == '0) begin
                            state_d    = DEAD;
                            iframe_clr = 1'b1;
                        end else begin
                            state_d     = IFRAME;
                            iframe_load = 1'b1;
                        end
                    end else if (heal_en) begin
                        hp_d = clamped;
                    end else if (regen_fire) begin
                        hp_d = hp + HPW'(1);
                    end
                end
                IFRAME: begin
                    if (heal_en) hp_d = clamped;
                    // A zero counter here can only mean a lost load; leave rather than stick.
                    if (iframe_zero) begin
                        state_d = ALIVE;
                    end else if (frame_tick && !heal_en) begin
                        iframe_tick = 1'b1;
                        if (iframe_cnt == IW'(1)) state_d = ALIVE;
                    end
                end
                DEAD: begin
                    hp_d = '0;
                end
                default: begin
                    state_d    = ALIVE;
                    hp_d       = INIT_V;
                    iframe_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ALIVE;
            hp    <= INIT_V;
        end else begin
            state <= state_d;
            hp    <= hp_d;
        end
    end

    // Status outputs decode directly from the state and counter flops.
    assign invincible = (state == IFRAME);
    assign dead       = (state == DEAD);
    assign hit_flash  = invincible & iframe_cnt[2];

endmodule

// File: tb/tb_hp_controller.sv
// Scoreboard bench for hp_controller: stimulus pushes expected outputs, a monitor pops and compares.
module tb_hp_controller;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       damage;
    logic [2:0] damage_amt;
    logic       heal;
    logic [2:0] heal_amt;
    logic       revive;
    logic [2:0] hp;
    logic       invincible;
    logic       dead;
    logic       hit_flash;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [2:0] hp;
        logic       inv;
        logic       dead;
        logic       flash;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    hp_controller dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .frame_tick (frame_tick),
        .damage     (damage),
        .damage_amt (damage_amt),
        .heal       (heal),
        .heal_amt   (heal_amt),
        .revive     (revive),
        .hp         (hp),
        .invincible (invincible),
        .dead       (dead),
        .hit_flash  (hit_flash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got hp=%0d inv=%b dead=%b flash=%b, expected hp=%0d inv=%b dead=%b flash=%b",
                     nm, act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: compares after the edge that consumed the matching stimulus.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check(mon_e.name, {hp, invincible, dead, hit_flash},
                  {mon_e.hp, mon_e.inv, mon_e.dead, mon_e.flash});
        end
    end

    task automatic apply(input logic dm, input logic [2:0] da, input logic hl,
                         input logic [2:0] ha, input logic rv, input logic tk);
        @(negedge clk);
        damage     = dm;
        damage_amt = da;
        heal       = hl;
        heal_amt   = ha;
        revive     = rv;
        frame_tick = tk;
    endtask

    task automatic step(input string nm, input logic dm, input logic [2:0] da, input logic hl,
                        input logic [2:0] ha, input logic rv, input logic tk,
                        input logic [2:0] eh, input logic ei, input logic ed, input logic ef);
        exp_t e;
        apply(dm, da, hl, ha, rv, tk);
        e.name  = nm;
        e.hp    = eh;
        e.inv   = ei;
        e.dead  = ed;
        e.flash = ef;
        sb.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        damage     = 1'b0;
        damage_amt = '0;
        heal       = 1'b0;
        heal_amt   = '0;
        revive     = 1'b0;

        // Reset values, then idle after release
        step("reset_values", 0, 0, 0, 0, 0, 0, 3'd7, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) apply(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        step("idle_after_reset", 0, 0, 0, 0, 0, 0, 3'd7, 0, 0, 0);

        // Damage enters iframes; 60 ticks end them
        step("dmg2_enter_iframe", 1, 3'd2, 0, 0, 0, 0, 3'd5, 1, 0, 1);
        step("iframe_tick1",      0, 0, 0, 0, 0, 1, 3'd5, 1, 0, 0);
        ticks(57);
        step("iframe_tick59",     0, 0, 0, 0, 0, 1, 3'd5, 1, 0, 0);
        step("iframe_tick60",     0, 0, 0, 0, 0, 1, 3'd5, 0, 0, 0);

        // Damage ignored during iframes, heal allowed and clamped
        step("revive_a",          0, 0, 0, 0, 1, 0, 3'd7, 0, 0, 0);
        step("dmg2_iframe_b",     1, 3'd2, 0, 0, 0, 0, 3'd5, 1, 0, 1);
        step("iframe_dmg3_ign",   1, 3'd3, 0, 0, 0, 0, 3'd5, 1, 0, 1);
        step("iframe_heal1",      0, 0, 1, 3'd1, 0, 0, 3'd6, 1, 0, 1);
        step("iframe_heal5_clamp",0, 0, 1, 3'd5, 0, 0, 3'd7, 1, 0, 1);
        step("iframe_tick_flash", 0, 0, 0, 0, 0, 1, 3'd7, 1, 0, 0);

        // Lethal damage, dead state ignores events, revive recovers
        step("revive_b",          0, 0, 0, 0, 1, 0, 3'd7, 0, 0, 0);
        step("dmg4_to_3",         1, 3'd4, 0, 0, 0, 0, 3'd3, 1, 0, 1);
        ticks(59);
        step("hp3_alive",         0, 0, 0, 0, 0, 1, 3'd3, 0, 0, 0);
        step("dmg5_dead",         1, 3'd5, 0, 0, 0, 0, 3'd0, 0, 1, 0);
        step("dead_heal_ign",     0, 0, 1, 3'd3, 0, 0, 3'd0, 0, 1, 0);
        step("dead_dmg_ign",      1, 3'd2, 0, 0, 0, 0, 3'd0, 0, 1, 0);
        step("dead_tick_ign",     0, 0, 0, 0, 0, 1, 3'd0, 0, 1, 0);
        step("revive_from_dead",  0, 0, 0, 0, 1, 0, 3'd7, 0, 0, 0);

        // Simultaneous damage + heal, and zero-amount damage
        step("dmg3_to_4",         1, 3'd3, 0, 0, 0, 0, 3'd4, 1, 0, 1);
        ticks(59);
        step("hp4_alive",         0, 0, 0, 0, 0, 1, 3'd4, 0, 0, 0);
        step("dmg2_heal3_net5",   1, 3'd2, 1, 3'd3, 0, 0, 3'd5, 1, 0, 1);
        ticks(59);
        step("hp5_alive",         0, 0, 0, 0, 0, 1, 3'd5, 0, 0, 0);
        step("dmg0_noop",         1, 3'd0, 0, 0, 0, 1, 3'd5, 0, 0, 0);
        step("dmg1_still_alive",  1, 3'd1, 0, 0, 0, 0, 3'd4, 1, 0, 1);
        ticks(59);
        step("hp4_alive_b",       0, 0, 0, 0, 0, 1, 3'd4, 0, 0, 0);
        step("dmg1_heal7_clamp",  1, 3'd1, 1, 3'd7, 0, 0, 3'd7, 1, 0, 1);
        step("revive_beats_dmg",  1, 3'd3, 0, 0, 1, 0, 3'd7, 0, 0, 0);
        step("dmg7_exact_zero",   1, 3'd7, 0, 0, 0, 0, 3'd0, 0, 1, 0);
        step("revive_c",          0, 0, 0, 0, 1, 0, 3'd7, 0, 0, 0);

        // Reset asserted mid-iframe
        step("dmg2_before_rst",   1, 3'd2, 0, 0, 0, 0, 3'd5, 1, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        step("mid_reset",         0, 0, 0, 0, 0, 1, 3'd7, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_reset_tick",  0, 0, 0, 0, 0, 1, 3'd7, 0, 0, 0);
        step("after_reset_dmg1",  1, 3'd1, 0, 0, 0, 0, 3'd6, 1, 0, 1);

`ifdef HP_REGEN_EN
        ticks(59);
        step("rg_hp6_alive",      0, 0, 0, 0, 0, 1, 3'd6, 0, 0, 0);
        step("rg_dmg1",           1, 3'd1, 0, 0, 0, 0, 3'd5, 1, 0, 1);
        ticks(59);
        step("rg_hp5_alive",      0, 0, 0, 0, 0, 1, 3'd5, 0, 0, 0);
        ticks(118);
        step("rg_tick119",        0, 0, 0, 0, 0, 1, 3'd5, 0, 0, 0);
        step("rg_tick120",        0, 0, 0, 0, 0, 1, 3'd6, 0, 0, 0);
        ticks(118);
        step("rg_dmg_at_119",     1, 3'd1, 0, 0, 0, 1, 3'd5, 1, 0, 1);
        ticks(59);
        step("rg_restart_alive",  0, 0, 0, 0, 0, 1, 3'd5, 0, 0, 0);
        ticks(118);
        step("rg_restart_119",    0, 0, 0, 0, 0, 1, 3'd5, 0, 0, 0);
        step("rg_restart_120",    0, 0, 0, 0, 0, 1, 3'd6, 0, 0, 0);
        step("rg_heal_to_max",    0, 0, 1, 3'd1, 0, 0, 3'd7, 0, 0, 0);
        ticks(129);
        step("rg_max_no_regen",   0, 0, 0, 0, 0, 1, 3'd7, 0, 0, 0);
`endif

        apply(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
